// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory/IO bridge: bus widths, I/O address map,
// read-region decode and the UART transmitter state encoding.
package mem_io_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_SW    = 12'hFFC;
  localparam logic [ADDR_W-1:0] ADDR_LED   = 12'hFFD;
  localparam logic [ADDR_W-1:0] ADDR_USTAT = 12'hFFE;
  localparam logic [ADDR_W-1:0] ADDR_UDATA = 12'hFFF;

  typedef enum logic [2:0] {
    RG_RAM,
    RG_SW,
    RG_LED,
    RG_USTAT,
    RG_UDATA
  } region_e;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  // Everything below the I/O window is RAM.
  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
    case (addr)
      ADDR_SW:    return RG_SW;
      ADDR_LED:   return RG_LED;
      ADDR_USTAT: return RG_USTAT;
      ADDR_UDATA: return RG_UDATA;
      default:    return RG_RAM;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter.
// Ports: clock/reset (sync, active-high); push/push_data enqueue a byte;
// full = FIFO holds FIFO_DEPTH bytes; busy = FIFO non-empty or a frame in
// flight; overflow = sticky, set when a push is dropped; txd = serial out.
// FIFO_DEPTH must be a power of two, at least 2; CLKS_PER_BIT at least 2.
module uart_tx_fifo
  import mem_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       txd
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);

  uart_state_e      state_q, state_d;
  logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];

  logic pop_c, push_ok_c, last_tick_c, nonempty_c;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= UART_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and FIFO bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Next-state logic. A pop is allowed in IDLE and on the final STOP cycle,
  // so queued bytes go out back-to-back with no idle gap.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    pop_c       = 1'b0;
    nonempty_c  = (count_q != '0);
    last_tick_c = (clk_cnt_q == CLK_W'(CLKS_PER_BIT - 1));
    case (state_q)
      UART_IDLE: begin
        if (nonempty_c) begin
          pop_c     = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          clk_cnt_d = '0;
          state_d   = UART_START;
        end
      end
      UART_START: begin
        if (last_tick_c) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = UART_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      UART_DATA: begin
        if (last_tick_c) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = UART_STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      UART_STOP: begin
        if (last_tick_c) begin
          clk_cnt_d = '0;
          if (nonempty_c) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  // Output logic: txd is registered from the upcoming state so the line
  // changes on the same edge the FSM does.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      UART_START: txd_d = 1'b0;
      UART_DATA:  txd_d = shift_d[0];
      default:    txd_d = 1'b1;
    endcase
  end

  // FIFO: a push into a full FIFO still fits if a pop frees a slot this cycle.
  always_comb begin
    mem_d      = mem_q;
    push_ok_c  = push & ((count_q != CNT_W'(FIFO_DEPTH)) | pop_c);
    overflow_d = overflow_q | (push & ~push_ok_c);
    if (push_ok_c) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok_c);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
    count_d    = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
  end

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign busy     = (count_q != '0) | (state_q != UART_IDLE);
  assign overflow = overflow_q;
  assign txd      = txd_q;

endmodule

// File: rtl/mem_io_bridge.sv
// Core memory-port bridge onto external synchronous RAM and memory-mapped I/O.
// Ports: clock/reset (sync, active-high); m_addr/m_rw/m_data from the core,
// m_q read data back (one cycle after the address); ram_* external RAM
// (address/we/wdata combinational, rdata one cycle late); sw_in switches;
// led_out LED register; uart_txd serial output (idle high).
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic              m_rw,
  input  logic [DATA_W-1:0] m_data,
  output logic [DATA_W-1:0] m_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] led_out,
  output logic              uart_txd
);

  region_e           region_c, region_q, region_d;
  logic              rw_prev_q, rw_prev_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
  logic [DATA_W-1:0] ustat_c;
  logic              wr_stb_c, push_c;
  logic              tx_full, tx_busy, tx_overflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      region_q   <= RG_UDATA;  // reads as zero until the first real access
      rw_prev_q  <= 1'b0;
      led_q      <= '0;
      io_rdata_q <= '0;
    end else begin
      region_q   <= region_d;
      rw_prev_q  <= rw_prev_d;
      led_q      <= led_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  // Decode, RAM drive, I/O write strobe and I/O read capture.
  always_comb begin
    region_c  = decode_region(m_addr);
    ram_addr  = m_addr;
    ram_wdata = m_data;
    ram_we    = m_rw & (region_c == RG_RAM);
    wr_stb_c  = m_rw & ~rw_prev_q;
    push_c    = wr_stb_c & (region_c == RG_UDATA);
    led_d     = led_q;
    if (wr_stb_c && (region_c == RG_LED)) led_d = m_data;
    ustat_c   = {{(DATA_W-3){1'b0}}, tx_overflow, tx_busy, tx_full};
    case (region_c)
      RG_SW:    io_rdata_d = sw_in;
      RG_LED:   io_rdata_d = led_q;
      RG_USTAT: io_rdata_d = ustat_c;
      default:  io_rdata_d = '0;
    endcase
    region_d  = region_c;
    rw_prev_d = m_rw;
  end

  // RAM data is already registered inside the RAM; I/O data was captured
  // here last cycle, so every region returns with the same latency.
  assign m_q     = (region_q == RG_RAM) ? ram_rdata : io_rdata_q;
  assign led_out = led_q;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (m_data[7:0]),
    .full      (tx_full),
    .busy      (tx_busy),
    .overflow  (tx_overflow),
    .txd       (uart_txd)
  );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: external RAM model, UART frame receiver and
// scenario tasks compared against expectations derived from the address map
// and 8N1 framing rules.
module tb_mem_io_bridge;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam logic [11:0] A_SW    = 12'hFFC;
  localparam logic [11:0] A_LED   = 12'hFFD;
  localparam logic [11:0] A_USTAT = 12'hFFE;
  localparam logic [11:0] A_UDATA = 12'hFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] m_addr = '0;
  logic        m_rw = 1'b0;
  logic [15:0] m_data = '0;
  logic [15:0] m_q;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic        uart_txd;

  int errors = 0;
  int checks = 0;

  mem_io_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .m_addr(m_addr), .m_rw(m_rw),
    .m_data(m_data), .m_q(m_q), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .sw_in(sw_in),
    .led_out(led_out), .uart_txd(uart_txd)
  );

  always #5 clock = ~clock;

  // External synchronous RAM (read-before-write).
  logic [15:0] ram_mem [4096];
  initial for (int i = 0; i < 4096; i++) ram_mem[i] = '0;
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Serial receiver: mid-bit sampling of 8N1 frames, aborts on reset.
  int         cyc = 0;
  logic       txd_prev = 1'b1;
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [9:0] rx_bits = '0;
  logic [7:0] rx_q[$];
  logic       rx_err_q[$];
  int         rx_start_cyc[$];

  always begin
    @(posedge clock);
    #2;
    cyc = cyc + 1;
    if (reset) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (txd_prev && !uart_txd) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
        rx_start_cyc.push_back(cyc);
      end
    end else begin
      rx_cnt = rx_cnt + 1;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_bits[rx_cnt / CPB] = uart_txd;
        if (rx_cnt / CPB == 9) begin
          rx_q.push_back(rx_bits[8:1]);
          rx_err_q.push_back((rx_bits[0] != 1'b0) || (rx_bits[9] != 1'b1));
          rx_busy = 1'b0;
        end
      end
    end
    txd_prev = reset ? 1'b1 : uart_txd;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_err_q.delete();
    rx_start_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; m_rw = 1'b0; m_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (m_q !== 16'h0000) begin errors++; $display("FAIL reset_m_q: got %h expected 0000", m_q); end
    checks++; if (led_out !== 16'h0000) begin errors++; $display("FAIL reset_led: got %h expected 0000", led_out); end
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", uart_txd); end
    m_addr = A_USTAT;
    tick();
    checks++; if (m_q !== 16'h0000) begin errors++; $display("FAIL reset_ustat: got %h expected 0000", m_q); end
  endtask

  task automatic test_ram();
    logic [15:0] exp_ram [int];
    logic [11:0] addrs [8];
    logic [11:0] a;
    logic [15:0] d;
    logic        exp_we;
    addrs[0] = 12'h010; addrs[1] = 12'h000; addrs[2] = 12'hFFB; addrs[3] = A_SW;
    for (int i = 4; i < 8; i++) addrs[i] = 12'($urandom_range(0, 12'hFFB));
    for (int i = 0; i < 8; i++) begin
      a = addrs[i];
      d = (i == 0) ? 16'h1234 : 16'($urandom);
      exp_we = (a < A_SW);
      m_addr = a; m_data = d; m_rw = 1'b1;
      #1;
      checks++; if (ram_we !== exp_we || ram_addr !== a || ram_wdata !== d) begin
        errors++; $display("FAIL ram_we_write[%0d]: got we=%b addr=%h wd=%h expected we=%b addr=%h wd=%h", i, ram_we, ram_addr, ram_wdata, exp_we, a, d);
      end
      if (exp_we) exp_ram[int'(a)] = d;
      tick();
      m_rw = 1'b0;
      #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_we_read[%0d]: got %b expected 0", i, ram_we); end
      tick();
      if (exp_we) begin
        checks++; if (m_q !== d) begin errors++; $display("FAIL ram_readback[%0d] addr %h: got %h expected %h", i, a, m_q, d); end
      end
    end
    foreach (exp_ram[k]) begin
      m_addr = 12'(k);
      tick();
      checks++; if (m_q !== exp_ram[k]) begin errors++; $display("FAIL ram_final addr %h: got %h expected %h", k, m_q, exp_ram[k]); end
    end
  endtask

  task automatic test_sw_led();
    logic [15:0] s, v, v2;
    for (int i = 0; i < 4; i++) begin
      s = (i == 0) ? 16'hBEEF : 16'($urandom);
      sw_in = s; m_addr = A_SW; m_rw = 1'b0;
      tick();
      checks++; if (m_q !== s) begin errors++; $display("FAIL sw_read[%0d]: got %h expected %h", i, m_q, s); end
    end
    v = 16'h00FF; v2 = 16'($urandom) | 16'h8000;
    m_addr = A_LED; m_data = v; m_rw = 1'b1;
    tick();
    checks++; if (led_out !== v) begin errors++; $display("FAIL led_write: got %h expected %h", led_out, v); end
    m_data = v2;  // still held high: no new strobe
    tick();
    checks++; if (led_out !== v) begin errors++; $display("FAIL led_held_write: got %h expected %h", led_out, v); end
    m_rw = 1'b0;
    tick();
    tick();
    checks++; if (m_q !== v) begin errors++; $display("FAIL led_read: got %h expected %h", m_q, v); end
    m_addr = A_UDATA;
    tick();
    checks++; if (m_q !== 16'h0000) begin errors++; $display("FAIL udata_read: got %h expected 0000", m_q); end
  endtask

  task automatic test_uart_frame();
    logic [7:0] b;
    logic [9:0] frame;
    logic       bad;
    b = 8'h41;
    frame = {1'b1, b, 1'b0};
    rx_clear();
    m_addr = A_UDATA; m_data = 16'h0041; m_rw = 1'b1;
    tick();
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL frame_pre_start: got %b expected 1", uart_txd); end
    tick();
    for (int k = 0; k < 10; k++) begin
      bad = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (uart_txd !== frame[k]) bad = 1'b1;
        if (k == 0 && c == 1) m_rw = 1'b0;
        tick();
      end
      checks++; if (bad) begin errors++; $display("FAIL frame_bit[%0d]: got %b expected %b", k, uart_txd, frame[k]); end
    end
    bad = 1'b0;
    m_addr = A_USTAT;
    for (int c = 0; c < 3 * CPB; c++) begin
      if (uart_txd !== 1'b1) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL frame_idle_after: got %b expected 1", uart_txd); end
    checks++; if (m_q !== 16'h0000) begin errors++; $display("FAIL frame_ustat_done: got %h expected 0000", m_q); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== b) begin
      errors++; $display("FAIL frame_rx: got %0d bytes first %h expected 1 byte %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, b);
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  sent[$];
    logic [7:0]  b;
    logic [15:0] exp_stat;
    int n_push   = 6;
    int accepted = (n_push < 1 + DEPTH) ? n_push : 1 + DEPTH;
    int budget;
    rx_clear();
    for (int j = 0; j < n_push; j++) begin
      b = 8'($urandom);
      if (j < accepted) sent.push_back(b);
      m_addr = A_UDATA; m_data = {8'($urandom), b}; m_rw = 1'b1;
      tick();
      m_rw = 1'b0;
      tick();
    end
    exp_stat = {13'd0, 1'(n_push > accepted), 1'b1, 1'(accepted - 1 >= DEPTH)};
    m_addr = A_USTAT;
    tick();
    checks++; if (m_q !== exp_stat) begin errors++; $display("FAIL ovf_ustat: got %h expected %h", m_q, exp_stat); end
    budget = accepted * 10 * CPB + 200;
    while (rx_q.size() < accepted && budget > 0) begin tick(); budget--; end
    checks++; if (rx_q.size() != accepted) begin errors++; $display("FAIL ovf_rx_count: got %0d expected %0d", rx_q.size(), accepted); end
    for (int j = 0; j < accepted && j < rx_q.size(); j++) begin
      checks++; if (rx_q[j] !== sent[j] || rx_err_q[j]) begin
        errors++; $display("FAIL ovf_rx_byte[%0d]: got %h err=%b expected %h", j, rx_q[j], rx_err_q[j], sent[j]);
      end
    end
    for (int j = 1; j < rx_start_cyc.size(); j++) begin
      checks++; if (rx_start_cyc[j] - rx_start_cyc[j-1] != 10 * CPB) begin
        errors++; $display("FAIL ovf_frame_spacing[%0d]: got %0d expected %0d", j, rx_start_cyc[j] - rx_start_cyc[j-1], 10 * CPB);
      end
    end
    repeat (CPB) tick();
    tick();
    checks++; if (m_q !== 16'h0004) begin errors++; $display("FAIL ovf_sticky: got %h expected 0004", m_q); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b, c2;
    logic       bad;
    int         budget;
    b = 8'($urandom) | 8'h10;  // bit4 set so the line is high when reset hits
    c2 = 8'($urandom);
    rx_clear();
    m_addr = A_UDATA; m_data = {8'h00, b}; m_rw = 1'b1;
    tick();
    m_rw = 1'b0;
    tick();
    m_data = {8'h00, c2}; m_rw = 1'b1;
    tick();
    m_rw = 1'b0;
    repeat (87) tick();
    checks++; if (uart_txd !== b[4]) begin errors++; $display("FAIL mid_bit4: got %b expected %b", uart_txd, b[4]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL mid_reset_txd: got %b expected 1", uart_txd); end
    m_addr = A_USTAT;
    tick();
    checks++; if (m_q !== 16'h0000) begin errors++; $display("FAIL mid_reset_ustat: got %h expected 0000", m_q); end
    bad = 1'b0;
    for (int c = 0; c < 2 * 10 * CPB; c++) begin
      if (uart_txd !== 1'b1) bad = 1'b1;
      tick();
    end
    checks++; if (bad || rx_q.size() != 0) begin errors++; $display("FAIL mid_no_resume: got bytes=%0d low=%b expected bytes=0 low=0", rx_q.size(), bad); end
    m_addr = A_UDATA; m_data = 16'h0055; m_rw = 1'b1;
    tick();
    m_rw = 1'b0;
    budget = 10 * CPB + 100;
    while (rx_q.size() < 1 && budget > 0) begin tick(); budget--; end
    repeat (2 * CPB) tick();
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55 || rx_err_q[0]) begin
      errors++; $display("FAIL mid_clean_frame: got %0d bytes first %h expected 1 byte 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_sw_led();
    test_uart_frame();
    test_overflow();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
